// File: rtl/pc_flags_restorer_pkg.sv
// -----------------------------------------------------------------------------
// pc_flags_restorer_pkg
// Shared definitions for the return-context restore (pop) path and the
// matching push-side selection logic:
//   - default stack word width and architectural flag count
//   - the restore FSM state encoding
//   - a small decode helper telling whether a state issues a stack read
// -----------------------------------------------------------------------------
package pc_flags_restorer_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int FLAG_WIDTH_DEF = 4;

  // Pop order mirrors the push order in reverse: PC low, PC high, flags.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    POP_LOW   = 3'd1,
    POP_HIGH  = 3'd2,
    POP_FLAGS = 3'd3,
    DONE      = 3'd4
  } restoreState_e;

  // True for every state that holds a stack read request open.
  function automatic logic isPopState(input restoreState_e s);
    return (s == POP_LOW) || (s == POP_HIGH) || (s == POP_FLAGS);
  endfunction

endpackage : pc_flags_restorer_pkg

// File: rtl/pc_flags_restorer_if.sv
// -----------------------------------------------------------------------------
// pc_flags_restorer_if
// Stack read port between the restore FSM and data memory / SP unit.
//   memReadReq   : read request, held high until accepted
//   memReadValid : read data valid; accepts the current request
//   memReadData  : stack word returned by memory
//   spInc        : one pulse per accepted word; SP post-increments
// Modports:
//   master : the restorer (drives memReadReq, spInc)
//   slave  : memory / SP side (drives memReadValid, memReadData)
// -----------------------------------------------------------------------------
interface pc_flags_restorer_if
  import pc_flags_restorer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic                  memReadReq;
  logic                  memReadValid;
  logic [DATA_WIDTH-1:0] memReadData;
  logic                  spInc;

  modport master (
    output memReadReq,
    output spInc,
    input  memReadValid,
    input  memReadData
  );

  modport slave (
    input  memReadReq,
    input  spInc,
    output memReadValid,
    output memReadData
  );

endinterface : pc_flags_restorer_if

// File: rtl/pc_flags_restorer.sv
// -----------------------------------------------------------------------------
// pc_flags_restorer
// Pops a saved return context off the data-memory stack on RET / RTI.
// Reads PC low, PC high and (RTI only) the flags word, reassembles the 32-bit
// PC, then pulses one-cycle load strobes to fetch and the flag register.
//
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   retStart   : one-cycle request to pop PC only
//   rtiStart   : one-cycle request to pop PC then flags (wins over retStart)
//   flush      : synchronous abort of an in-flight pop
//   mem        : stack read port (master side)
//   busy       : restore in progress, fetch is stalled while high
//   pcOut      : restored PC {high, low}, registered
//   pcLoad     : one-cycle strobe, fetch loads pcOut
//   flagsOut   : restored flags, registered
//   flagsLoad  : one-cycle strobe, flag register loads flagsOut
// -----------------------------------------------------------------------------
module pc_flags_restorer
  import pc_flags_restorer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FLAG_WIDTH = FLAG_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    retStart,
  input  logic                    rtiStart,
  input  logic                    flush,
  pc_flags_restorer_if.master     mem,
  output logic                    busy,
  output logic [2*DATA_WIDTH-1:0] pcOut,
  output logic                    pcLoad,
  output logic [FLAG_WIDTH-1:0]   flagsOut,
  output logic                    flagsLoad
);

  restoreState_e         state;
  restoreState_e         nextState;
  logic                  isRti;
  logic [DATA_WIDTH-1:0] pcLowReg;

  logic startReq;
  logic wordAccept;
  logic readReq;
  logic spIncPulse;

  // A start in IDLE is taken even if flush is high: flush only aborts an
  // in-flight pop. flush also blocks acceptance, so no word is consumed in
  // the abort cycle.
  assign startReq   = retStart | rtiStart;
  assign wordAccept = isPopState(state) & mem.memReadValid & ~flush;

  assign mem.memReadReq = readReq;
  assign mem.spInc      = spIncPulse;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state decode
  always_comb begin
    nextState = state;
    if (flush && (state != IDLE)) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (startReq) begin
            nextState = POP_LOW;
          end else begin
            nextState = IDLE;
          end
        end
        POP_LOW: begin
          if (mem.memReadValid) begin
            nextState = POP_HIGH;
          end else begin
            nextState = POP_LOW;
          end
        end
        POP_HIGH: begin
          if (mem.memReadValid) begin
            nextState = isRti ? POP_FLAGS : DONE;
          end else begin
            nextState = POP_HIGH;
          end
        end
        POP_FLAGS: begin
          if (mem.memReadValid) begin
            nextState = DONE;
          end else begin
            nextState = POP_FLAGS;
          end
        end
        DONE: begin
          nextState = IDLE;
        end
        default: begin
          nextState = IDLE;
        end
      endcase
    end
  end

  // Output decode: strobes come straight from state so they line up with the
  // cycle the FSM is in; a flush in DONE suppresses the loads.
  always_comb begin
    readReq    = 1'b0;
    spIncPulse = 1'b0;
    busy       = 1'b0;
    pcLoad     = 1'b0;
    flagsLoad  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
      end
      POP_LOW, POP_HIGH, POP_FLAGS: begin
        busy       = 1'b1;
        readReq    = 1'b1;
        spIncPulse = wordAccept;
      end
      DONE: begin
        busy      = 1'b1;
        pcLoad    = ~flush;
        flagsLoad = isRti & ~flush;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Request-type latch: captured only when a start is taken in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isRti <= 1'b0;
    end else if ((state == IDLE) && startReq) begin
      isRti <= rtiStart;
    end
  end

  // Datapath bank: each accepted word lands in the register for its slot.
  // PC halves are concatenated as-is, no offset arithmetic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcLowReg <= '0;
      pcOut    <= '0;
      flagsOut <= '0;
    end else if (wordAccept) begin
      case (state)
        POP_LOW:   pcLowReg <= mem.memReadData;
        POP_HIGH:  pcOut    <= {mem.memReadData, pcLowReg};
        POP_FLAGS: flagsOut <= mem.memReadData[FLAG_WIDTH-1:0];
        default:   pcLowReg <= pcLowReg;
      endcase
    end
  end

endmodule : pc_flags_restorer

// File: doc/pc_flags_restorer.md
# pc_flags_restorer

Pops a saved return context off the data-memory stack on RET and RTI. It issues sequential 16-bit stack reads, reassembles the 32-bit PC from low/high halves, optionally restores the 4-bit flags, then presents them to the fetch stage and flag register with one-cycle load strobes. It sits beside the memory stage and is the read-side counterpart of the call/interrupt push path. Stack order on push is flags (RTI only), then PC high, then PC low, so the pop order is PC low, PC high, then flags.

## Interface
- DATA_WIDTH, 16, width of one stack word
- FLAG_WIDTH, 4, number of architectural flags
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- retStart  in  1  one-cycle request to pop PC only
- rtiStart  in  1  one-cycle request to pop PC then flags
- flush  in  1  synchronous abort of an in-flight pop
- memReadReq  out  1  stack read request, held until accepted
- memReadValid  in  1  read data valid; accepts the current request
- memReadData  in  DATA_WIDTH  stack word returned by memory
- spInc  out  1  one pulse per accepted word; SP unit post-increments
- busy  out  1  restore in progress; the pipeline stalls fetch while high
- pcOut  out  2*DATA_WIDTH  restored PC {high, low}, registered
- pcLoad  out  1  one-cycle strobe: fetch loads pcOut
- flagsOut  out  FLAG_WIDTH  restored flags, registered
- flagsLoad  out  1  one-cycle strobe: flag register loads flagsOut

Clock and reset: one clock; reset is asynchronous and active-low.

## Operation
- FSM states: IDLE, POP_LOW, POP_HIGH, POP_FLAGS, DONE.
- IDLE:
  - retStart or rtiStart moves the FSM to POP_LOW and latches isRti = rtiStart.
  - If both are asserted together, RTI wins.
  - Starts are ignored in every non-IDLE state.
- POP_LOW:
  - memReadReq = 1.
  - On memReadValid: pcLowReg <= memReadData, spInc = 1, go to POP_HIGH.
- POP_HIGH:
  - memReadReq = 1.
  - On memReadValid: pcOut <= {memReadData, pcLowReg}, spInc = 1.
  - Next state is POP_FLAGS if isRti, else DONE.
- POP_FLAGS:
  - memReadReq = 1.
  - On memReadValid: flagsOut <= memReadData[FLAG_WIDTH-1:0], with the upper bits discarded; spInc = 1; go to DONE.
- DONE:
  - pcLoad = 1; flagsLoad = isRti.
  - Return to IDLE next cycle.
- Without memReadValid, every POP state holds and keeps memReadReq high. There is no timeout.
- flush:
  - In any non-IDLE state, flush returns the FSM to IDLE next cycle with no pcLoad or flagsLoad.
  - Words already accepted are not un-popped; the SP unit handles recovery.
  - flush in IDLE is a no-op.
  - flush wins over memReadValid in the same cycle, so spInc = 0.
- busy = (state != IDLE). memReadReq, spInc, pcLoad and flagsLoad are decoded from state and inputs, with no extra register.
- PC halves are concatenated unmodified; there is no adjustment or offset arithmetic.

## Timing
- Reset values: state IDLE; isRti 0; pcLowReg 0, pcOut 0, flagsOut 0. All strobes, busy and memReadReq are 0.
- Start is sampled at cycle T; memReadReq and busy rise at T+1.
- Zero-wait memory (memReadValid = 1 whenever requested):
  - RET: words accepted at T+1 and T+2; pcLoad at T+3; busy low at T+4.
  - RTI: words accepted at T+1..T+3; pcLoad and flagsLoad together at T+4.
- Each wait cycle on memReadValid adds exactly one cycle.
- pcOut and flagsOut are stable from the load-strobe cycle until the next restore overwrites them.
- A reset assertion mid-restore clears everything immediately, and no strobes fire.
- A new start is accepted in IDLE at T+4 (RET) or T+5 (RTI) at the earliest.

## Structure
- Shared package: the state encoding enum (IDLE, POP_LOW, POP_HIGH, POP_FLAGS, DONE) and the DATA_WIDTH/FLAG_WIDTH defaults. These are shared with the push-side selection logic.
- No sub-module is needed: a single FSM with a datapath register bank.

## Test plan
- Reset then RET, memory returning 0x1234 then 0x00AB with no waits: spInc pulses at T+1 and T+2; pcOut = 0x00AB1234 with pcLoad at T+3; flagsLoad stays 0.
- RTI returning 0x0010, 0x0002, 0xFFF5: pcOut = 0x00020010; flagsOut = 0x5; pcLoad and flagsLoad both high at T+4.
- RET with memReadValid low for 3 cycles on each word: memReadReq held high throughout, exactly 2 spInc pulses, pcLoad at T+9.
- retStart and rtiStart in the same cycle: RTI sequence runs with three reads; a retStart while busy produces no extra reads.
- flush asserted during POP_HIGH together with memReadValid: spInc = 0, IDLE next cycle, no strobes, pcOut unchanged from its prior value.
- rst_n pulled low during POP_FLAGS: outputs immediately at reset values; a following RET completes normally.
